// File: rtl/mul_div_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_seq_pkg
// Description : Shared constants and types for the sequential MULTU/DIVU unit:
//               shared-ALU control codes, operation encodings, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_div_seq_pkg;

    // Control codes understood by the shared ALU
    localparam logic [3:0] C_ALU_AND = 4'd0;
    localparam logic [3:0] C_ALU_OR  = 4'd1;
    localparam logic [3:0] C_ALU_ADD = 4'd2;
    localparam logic [3:0] C_ALU_SUB = 4'd6;
    localparam logic [3:0] C_ALU_SLT = 4'd7;
    localparam logic [3:0] C_ALU_NOR = 4'd12;

    // Operation select encodings
    localparam logic C_OP_MULTU = 1'b0;
    localparam logic C_OP_DIVU  = 1'b1;

    // Number of granted shift/add (or shift/subtract) steps per operation
    localparam int unsigned C_NUM_ITER = 32;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mul_div_step.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_step
// Description : Combinational single iteration of the shift/add multiplier
//               and restoring divider. Chooses the shared-ALU operands for the
//               selected operation and forms the next hi/lo from the ALU
//               result. Divide datapath is present only when the macro
//               MUL_DIV_SEQ_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_step
    import mul_div_seq_pkg::*;
(
    input  logic        op_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] operand_i,
    input  logic [31:0] alu_result_i,
    input  logic        alu_cout_i,
    output logic [3:0]  alu_ctl_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [31:0] hi_next_o,
    output logic [31:0] lo_next_o
);

`ifdef MUL_DIV_SEQ_DIV_EN
    // Partial remainder shifted left by one, pulling in the next dividend bit
    logic [31:0] w_sh;
    assign w_sh = {hi_i[30:0], lo_i[31]};
`else
    // Only multiplication is built, so the op select has no effect here
    logic w_unused_op;
    assign w_unused_op = op_i;
`endif

    // Operand selection and next hi/lo for one iteration
    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is
        // set, then shift the 65-bit {cout, hi, lo} right by one.
        alu_ctl_o = C_ALU_ADD;
        alu_a_o   = hi_i;
        alu_b_o   = lo_i[0] ? operand_i : 32'd0;
        hi_next_o = {alu_cout_i, alu_result_i[31:1]};
        lo_next_o = {alu_result_i[0], lo_i[31:1]};
`ifdef MUL_DIV_SEQ_DIV_EN
        if (op_i == C_OP_DIVU) begin
            // Restoring divide: trial-subtract the divisor from the shifted
            // remainder. A set hi[31] means the shifted value is really 33
            // bits wide and therefore always exceeds the divisor.
            alu_ctl_o = C_ALU_SUB;
            alu_a_o   = w_sh;
            alu_b_o   = operand_i;
            if (hi_i[31] | alu_cout_i) begin
                hi_next_o = alu_result_i;
                lo_next_o = {lo_i[30:0], 1'b1};
            end else begin
                hi_next_o = w_sh;
                lo_next_o = {lo_i[30:0], 1'b0};
            end
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_seq
// Description : Sequential 32x32 unsigned multiply (MULTU) and, optionally,
//               unsigned divide (DIVU). One iteration per granted cycle of a
//               shared ALU; results land in hi/lo.
//               Optional feature macro: MUL_DIV_SEQ_DIV_EN (enables DIVU).
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_seq
    import mul_div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [3:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_cout
);

    state_e      state_q;
    logic [4:0]  count_q;
    logic        op_q;
    logic [31:0] src_a_q;
    logic [31:0] src_b_q;
    logic [31:0] operand_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        alu_req_q;

    logic        w_start_ok;
    logic        w_iter;
    logic [3:0]  w_step_ctl;
    logic [31:0] w_step_a;
    logic [31:0] w_step_b;
    logic [31:0] w_hi_next;
    logic [31:0] w_lo_next;

    // A start request is accepted only for operations this build supports
`ifdef MUL_DIV_SEQ_DIV_EN
    assign w_start_ok = start;
`else
    assign w_start_ok = start & (op == C_OP_MULTU);
`endif

    assign w_iter = (state_q == S_ITER);

    mul_div_step u_step (
        .op_i         (op_q),
        .hi_i         (hi_q),
        .lo_i         (lo_q),
        .operand_i    (operand_q),
        .alu_result_i (alu_result),
        .alu_cout_i   (alu_cout),
        .alu_ctl_o    (w_step_ctl),
        .alu_a_o      (w_step_a),
        .alu_b_o      (w_step_b),
        .hi_next_o    (w_hi_next),
        .lo_next_o    (w_lo_next)
    );

    // The shared ALU sees our operands only while iterating; they derive
    // purely from registers, so they stay frozen while the grant is withheld.
    assign alu_ctl = w_iter ? w_step_ctl : 4'd0;
    assign alu_a   = w_iter ? w_step_a   : 32'd0;
    assign alu_b   = w_iter ? w_step_b   : 32'd0;

    assign busy    = busy_q;
    assign done    = done_q;
    assign alu_req = alu_req_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

    // Sequencer: state, iteration counter, datapath registers and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= 5'd0;
            op_q      <= C_OP_MULTU;
            src_a_q   <= 32'd0;
            src_b_q   <= 32'd0;
            operand_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_req_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    // hi/lo keep the previous result until LOAD
                    if (w_start_ok) begin
                        state_q <= S_LOAD;
                        op_q    <= op;
                        src_a_q <= rs_val;
                        src_b_q <= rt_val;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    state_q   <= S_ITER;
                    count_q   <= 5'd0;
                    hi_q      <= 32'd0;
                    alu_req_q <= 1'b1;
                    if (op_q == C_OP_DIVU) begin
                        lo_q      <= src_a_q;
                        operand_q <= src_b_q;
                    end else begin
                        lo_q      <= src_b_q;
                        operand_q <= src_a_q;
                    end
                end
                S_ITER: begin
                    if (alu_gnt) begin
                        hi_q    <= w_hi_next;
                        lo_q    <= w_lo_next;
                        count_q <= count_q + 5'd1;
                        if (count_q == 5'(C_NUM_ITER - 1)) begin
                            state_q   <= S_DONE;
                            busy_q    <= 1'b0;
                            alu_req_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mul_div_seq.md
MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 SHALL have ports: clk in 1, system clock, all state updates on its rising edge.
REQ-002 SHALL have ports: rst in 1, synchronous active-high reset.
REQ-003 SHALL have ports: start in 1, request a new operation; sampled only in IDLE or DONE.
REQ-004 SHALL have ports: op in 1, operation select: 0 = MULTU, 1 = DIVU.
REQ-005 SHALL have ports: rs_val in 32, multiplicand or dividend; rt_val in 32, multiplier or divisor.
REQ-006 SHALL have ports: busy out 1, pipeline stall request; done out 1, one-cycle completion pulse.
REQ-007 SHALL have ports: hi out 32, lo out 32, result registers.
REQ-008 SHALL have ports: alu_req out 1, shared ALU request; alu_gnt in 1, shared ALU grant.
REQ-009 SHALL have ports: alu_ctl out 4, alu_a out 32, alu_b out 32, driving the shared ALU.
REQ-010 SHALL have ports: alu_result in 32, alu_cout in 1, ALU sum and carry-out, same cycle.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, ITER, DONE.
REQ-012 IDLE/DONE with start=1 SHALL go to LOAD, capturing rs_val/rt_val; start in LOAD/ITER SHALL be ignored.
REQ-013 LOAD SHALL go to ITER with iteration count 0: MULTU hi=0, lo=rt_val, operand register=rs_val; DIVU hi=0, lo=rs_val, operand register=rt_val.
REQ-014 ITER SHALL assert alu_req; an iteration completes only in a cycle with alu_gnt=1; alu_gnt=0 SHALL hold all state, alu_ctl, alu_a and alu_b.
REQ-015 MULTU iteration: alu_ctl=2 (ADD), alu_a=hi, alu_b = lo[0] ? operand : 0; hi <= {alu_cout, alu_result[31:1]}; lo <= {alu_result[0], lo[31:1]}.
REQ-016 DIVU iteration (restoring): sh={hi[30:0],lo[31]}; alu_ctl=6 (SUB), alu_a=sh, alu_b=operand.
REQ-017 DIVU accept: if hi[31] | alu_cout then hi <= alu_result, lo <= {lo[30:0],1}; else hi <= sh, lo <= {lo[30:0],0}.
REQ-018 After the 32nd granted iteration SHALL go to DONE; DONE asserts done=1 for one cycle and returns to IDLE unless start=1.
REQ-019 busy SHALL be 1 in LOAD and ITER, 0 otherwise; alu_req SHALL be 1 only in ITER.
REQ-020 With continuous grant, start high in cycle 0 SHALL give done=1 in cycle 34.
REQ-021 Outside ITER, alu_ctl, alu_a and alu_b SHALL be 0.
REQ-022 hi/lo SHALL hold the final result from DONE until the next LOAD.
REQ-023 DIVU by zero SHALL need no special case: yields lo=0xFFFFFFFF, hi=dividend.
REQ-024 Arithmetic SHALL be unsigned only.

Reset
REQ-025 rst=1 SHALL force IDLE, count=0, and busy, done, alu_req=0 and hi, lo, alu_ctl, alu_a, alu_b=0 at the next edge.
REQ-026 Reset mid-operation SHALL abandon the operation with no done pulse; start is honoured in the first cycle after rst deasserts.

Configuration
REQ-027 Macro MUL_DIV_SEQ_DIV_EN defined: DIVU supported per REQ-016/017.
REQ-028 Macro absent: start with op=1 SHALL be ignored (FSM stays IDLE, busy=0), and no SUB path SHALL be built.

Structure
REQ-029 A shared package SHALL hold the ALU control constants (AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12), the op encodings, and the FSM state enum.
REQ-030 There SHALL be one sub-module, mul_div_step: combinational next-hi/lo and ALU operand selection per op; the FSM and counter remain in mul_div_seq.

Verification
REQ-031 MULTU 7*6, gnt=1: done in cycle 34, hi=0x00000000, lo=0x0000002A, busy=1 in cycles 1-33.
REQ-032 MULTU 0xFFFFFFFF*0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 MULTU 3*5 with alu_gnt toggling 1/0 each ITER cycle: done in cycle 65, lo=15; ALU outputs stable while gnt=0.
REQ-034 DIVU 100/7 (DIV_EN): lo=14, hi=2; DIVU 0x1234/0: lo=0xFFFFFFFF, hi=0x1234; without DIV_EN, op=1: busy stays 0.
REQ-035 rst at cycle 10 of MULTU: next cycle busy=0, alu_req=0, hi=lo=0, no done; new start completes correctly.
REQ-036 start during ITER ignored; start in the DONE cycle gives busy=1 in the next cycle and a second correct result.
